// File: rtl/bht_controller_pkg.sv
// Shared types and constants for the branch history table controller:
// FSM states, counter/index widths, counter encodings and the update-queue entry.
package bht_controller_pkg;

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned N_ENTRIES = 16;

    localparam logic [CNT_W-1:0] SNT = 2'b00;
    localparam logic [CNT_W-1:0] WNT = 2'b01;
    localparam logic [CNT_W-1:0] WT  = 2'b10;
    localparam logic [CNT_W-1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RMW_RD = 2'd1,
        S_RMW_WR = 2'd2
    } bht_state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } uq_entry_t;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                    input logic             taken);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        unique case (cnt)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bht_controller_uq.sv
// Update queue: DEPTH-entry FIFO of (idx, taken) with registered full/empty flags,
// so upd_ready never depends combinationally on the dequeue.
module bht_controller_uq
    import bht_controller_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  uq_entry_t din_i,
    input  logic      pop_i,
    output uq_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    uq_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            full_q;
    logic            empty_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/decoder_four_sixteen.sv
// 4-to-16 one-hot decoder with enable; drives the counter-table write strobes.
module decoder_four_sixteen (
    input  logic [3:0]  in_i,
    input  logic        en_i,
    output logic [15:0] out_o
);

    always_comb begin
        out_o = '0;
        if (en_i) out_o[in_i] = 1'b1;
    end

endmodule

// File: rtl/bht_controller.sv
// Branch history table: 16 two-bit counters, single-cycle predictions and
// queued read-modify-write updates. Define BHT_STATS_EN to add update/mispredict counters.
module bht_controller
    import bht_controller_pkg::*;
#(
    parameter logic [CNT_W-1:0] INIT_STATE = WNT,
    parameter int unsigned      UQ_DEPTH   = 2,
    parameter int unsigned      STARVE_MAX = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pred_valid_i,
    input  logic [IDX_W-1:0] pred_idx_i,
    output logic             pred_ready_o,
    output logic             pred_rsp_valid_o,
    output logic             pred_taken_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i,
    output logic             upd_ready_o,
    output logic             idle_o
`ifdef BHT_STATS_EN
    ,
    output logic [15:0]      stat_upd_cnt_o,
    output logic [15:0]      stat_mispred_cnt_o
`endif
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    bht_state_e           state_q;
    bht_state_e           state_d;
    logic                 go_rmw;
    logic [SW-1:0]        starve_q;
    logic                 pred_ready_q;
    logic                 rsp_valid_q;
    logic                 taken_q;
    logic [CNT_W-1:0]     rmw_cnt_q;
    logic [CNT_W-1:0]     new_cnt;
    logic [CNT_W-1:0]     table_q [N_ENTRIES];
    logic [N_ENTRIES-1:0] wr_en;
    logic                 pred_acc;
    uq_entry_t            uq_din;
    uq_entry_t            uq_head;
    logic                 uq_full;
    logic                 uq_empty;
    logic                 uq_pop;

    assign uq_din = '{idx: upd_idx_i, taken: upd_taken_i};
    assign uq_pop = (state_q == S_RMW_WR);

    bht_controller_uq #(.DEPTH(UQ_DEPTH)) u_uq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (upd_valid_i),
        .din_i   (uq_din),
        .pop_i   (uq_pop),
        .head_o  (uq_head),
        .full_o  (uq_full),
        .empty_o (uq_empty)
    );

    decoder_four_sixteen u_dec (
        .in_i  (uq_head.idx),
        .en_i  (state_q == S_RMW_WR),
        .out_o (wr_en)
    );

    assign pred_acc = pred_valid_i && pred_ready_q;
    assign new_cnt  = sat_update(rmw_cnt_q, uq_head.taken);

    // Predictions win in IDLE until the queue fills or the head has waited STARVE_MAX cycles.
    always_comb begin
        state_d = state_q;
        go_rmw  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!uq_empty && (!pred_valid_i || uq_full || starve_q == SW'(STARVE_MAX))) begin
                    go_rmw  = 1'b1;
                    state_d = S_RMW_RD;
                end
            end
            S_RMW_RD: state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            pred_ready_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            rmw_cnt_q    <= SNT;
        end else begin
            state_q      <= state_d;
            pred_ready_q <= (state_d == S_IDLE);
            rsp_valid_q  <= pred_acc;
            if (pred_acc) taken_q <= table_q[pred_idx_i][1];
            if (go_rmw) begin
                starve_q <= '0;
            end else if (!uq_empty && pred_acc && starve_q != SW'(STARVE_MAX)) begin
                starve_q <= starve_q + SW'(1);
            end
            if (state_q == S_RMW_RD) rmw_cnt_q <= table_q[uq_head.idx];
        end
    end

    // Reset has priority, so an update caught mid-RMW is dropped without a write.
    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_tbl
        always_ff @(posedge clk_i) begin
            if (rst_i)         table_q[g] <= INIT_STATE;
            else if (wr_en[g]) table_q[g] <= new_cnt;
        end
    end

`ifdef BHT_STATS_EN
    logic [15:0] stat_upd_q;
    logic [15:0] stat_mis_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else if (state_q == S_RMW_WR) begin
            stat_upd_q <= stat_upd_q + 16'(1);
            if (uq_head.taken != rmw_cnt_q[1]) stat_mis_q <= stat_mis_q + 16'(1);
        end
    end

    assign stat_upd_cnt_o     = stat_upd_q;
    assign stat_mispred_cnt_o = stat_mis_q;
`endif

    assign pred_ready_o     = pred_ready_q;
    assign pred_rsp_valid_o = rsp_valid_q;
    assign pred_taken_o     = taken_q;
    assign upd_ready_o      = !uq_full;
    assign idle_o           = pred_ready_q && uq_empty;

endmodule

// File: tb/tb_bht_controller.sv
// Directed bench for bht_controller: a cycle-by-cycle vector table followed by
// hand-written starvation, full-queue and reset-during-RMW sequences.
module tb_bht_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [3:0]  pred_idx;
    logic        pred_ready;
    logic        pred_rsp_valid;
    logic        pred_taken;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic        upd_taken;
    logic        upd_ready;
    logic        idle;
`ifdef BHT_STATS_EN
    logic [15:0] stat_upd_cnt;
    logic [15:0] stat_mispred_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    bht_controller dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pred_valid_i     (pred_valid),
        .pred_idx_i       (pred_idx),
        .pred_ready_o     (pred_ready),
        .pred_rsp_valid_o (pred_rsp_valid),
        .pred_taken_o     (pred_taken),
        .upd_valid_i      (upd_valid),
        .upd_idx_i        (upd_idx),
        .upd_taken_i      (upd_taken),
        .upd_ready_o      (upd_ready),
        .idle_o           (idle)
`ifdef BHT_STATS_EN
        ,
        .stat_upd_cnt_o     (stat_upd_cnt),
        .stat_mispred_cnt_o (stat_mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    // stim = {pred_valid, pred_idx, upd_valid, upd_idx, upd_taken}
    // expv = {pred_ready, pred_rsp_valid, pred_taken, upd_ready, idle} seen in that cycle
    typedef struct packed {
        logic [10:0] stim;
        logic [4:0]  expv;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [10:0] s, input logic [4:0] e);
        vec_t v;
        v.stim = s;
        v.expv = e;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic pv, input logic [3:0] pi, input logic uv,
                         input logic [3:0] ui, input logic ut);
        pred_valid = pv;
        pred_idx   = pi;
        upd_valid  = uv;
        upd_idx    = ui;
        upd_taken  = ut;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

`ifdef BHT_STATS_EN
    // One update from an empty queue with no predictions: push, RMW_RD, RMW_WR, back in IDLE.
    task automatic single_update(input logic [3:0] idx, input logic t);
        drive(1'b0, 4'd0, 1'b1, idx, t);
        step();
        idle_inputs();
        repeat (3) step();
    endtask
`endif

    initial begin
        // Three taken updates to idx 3 (one dropped while full), a saturating fourth,
        // then predictions showing held pred_taken and no bypass for idx 9.
        vecs[0]  = mk(11'b1_0101_0_0000_0, 5'b1_0_0_1_1);
        vecs[1]  = mk(11'b0_0000_0_0000_0, 5'b1_1_0_1_1);
        vecs[2]  = mk(11'b0_0000_1_0011_1, 5'b1_0_0_1_1);
        vecs[3]  = mk(11'b0_0000_1_0011_1, 5'b1_0_0_1_0);
        vecs[4]  = mk(11'b0_0000_1_0011_1, 5'b0_0_0_0_0);
        vecs[5]  = mk(11'b0_0000_0_0000_0, 5'b0_0_0_0_0);
        vecs[6]  = mk(11'b0_0000_1_0011_1, 5'b1_0_0_1_0);
        vecs[7]  = mk(11'b0_0000_0_0000_0, 5'b0_0_0_0_0);
        vecs[8]  = mk(11'b0_0000_0_0000_0, 5'b0_0_0_0_0);
        vecs[9]  = mk(11'b0_0000_0_0000_0, 5'b1_0_0_1_0);
        vecs[10] = mk(11'b0_0000_1_0011_1, 5'b0_0_0_1_0);
        vecs[11] = mk(11'b0_0000_0_0000_0, 5'b0_0_0_0_0);
        vecs[12] = mk(11'b0_0000_0_0000_0, 5'b1_0_0_1_0);
        vecs[13] = mk(11'b0_0000_0_0000_0, 5'b0_0_0_1_0);
        vecs[14] = mk(11'b0_0000_0_0000_0, 5'b0_0_0_1_0);
        vecs[15] = mk(11'b1_0011_0_0000_0, 5'b1_0_0_1_1);
        vecs[16] = mk(11'b0_0000_0_0000_0, 5'b1_1_1_1_1);
        vecs[17] = mk(11'b1_0101_0_0000_0, 5'b1_0_1_1_1);
        vecs[18] = mk(11'b1_1001_1_1001_1, 5'b1_1_0_1_1);
        vecs[19] = mk(11'b1_1001_0_0000_0, 5'b1_1_0_1_0);
        vecs[20] = mk(11'b0_0000_0_0000_0, 5'b1_1_0_1_0);
        vecs[21] = mk(11'b0_0000_0_0000_0, 5'b0_0_0_1_0);
        vecs[22] = mk(11'b0_0000_0_0000_0, 5'b0_0_0_1_0);
        vecs[23] = mk(11'b1_1001_0_0000_0, 5'b1_0_0_1_1);
        vecs[24] = mk(11'b0_0000_0_0000_0, 5'b1_1_1_1_1);

        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            chk1($sformatf("v%0d pred_ready", i),     pred_ready,     vecs[i].expv[4]);
            chk1($sformatf("v%0d pred_rsp_valid", i), pred_rsp_valid, vecs[i].expv[3]);
            chk1($sformatf("v%0d pred_taken", i),     pred_taken,     vecs[i].expv[2]);
            chk1($sformatf("v%0d upd_ready", i),      upd_ready,      vecs[i].expv[1]);
            chk1($sformatf("v%0d idle", i),           idle,           vecs[i].expv[0]);
            {pred_valid, pred_idx, upd_valid, upd_idx, upd_taken} = vecs[i].stim;
            step();
        end
        idle_inputs();

        // Starvation: continuous predictions with one queued update.
        drive(1'b1, 4'd0, 1'b1, 4'd1, 1'b0);
        step();
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            chk1($sformatf("starve defer%0d pred_ready", k), pred_ready, 1'b1);
            step();
        end
        chk1("starve rmw_rd pred_ready", pred_ready, 1'b0);
        step();
        chk1("starve rmw_wr pred_ready", pred_ready, 1'b0);
        step();
        chk1("starve done pred_ready", pred_ready, 1'b1);
        chk1("starve done idle", idle, 1'b1);
        idle_inputs();
        step();

        // Full queue forces RMW despite pred_valid.
        drive(1'b1, 4'd0, 1'b1, 4'd2, 1'b1);
        step();
        chk1("full q1 upd_ready", upd_ready, 1'b1);
        chk1("full q1 idle", idle, 1'b0);
        drive(1'b1, 4'd0, 1'b1, 4'd4, 1'b1);
        step();
        chk1("full q2 upd_ready", upd_ready, 1'b0);
        chk1("full q2 pred_ready", pred_ready, 1'b1);
        drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        step();
        chk1("full rmw_rd pred_ready", pred_ready, 1'b0);
        chk1("full rmw_rd upd_ready", upd_ready, 1'b0);
        step();
        chk1("full rmw_wr pred_ready", pred_ready, 1'b0);
        chk1("full rmw_wr upd_ready", upd_ready, 1'b0);
        step();
        chk1("full after_wr upd_ready", upd_ready, 1'b1);
        chk1("full after_wr pred_ready", pred_ready, 1'b1);
        idle_inputs();
        repeat (3) step();
        chk1("full drained idle", idle, 1'b1);
        drive(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
        step();
        chk1("full idx2 rsp", pred_rsp_valid, 1'b1);
        chk1("full idx2 taken", pred_taken, 1'b1);
        drive(1'b1, 4'd4, 1'b0, 4'd0, 1'b0);
        step();
        chk1("full idx4 taken", pred_taken, 1'b1);
        idle_inputs();
        step();

        // Reset while RMW_WR for idx 7 is in flight.
        drive(1'b0, 4'd0, 1'b1, 4'd7, 1'b1);
        step();
        idle_inputs();
        repeat (2) step();
        chk1("rst_rmw in_wr pred_ready", pred_ready, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("rst_rmw pred_ready", pred_ready, 1'b1);
        chk1("rst_rmw upd_ready", upd_ready, 1'b1);
        chk1("rst_rmw idle", idle, 1'b1);
        chk1("rst_rmw rsp", pred_rsp_valid, 1'b0);
        chk1("rst_rmw taken", pred_taken, 1'b0);
`ifdef BHT_STATS_EN
        chk16("rst stat_upd", stat_upd_cnt, 16'd0);
        chk16("rst stat_mispred", stat_mispred_cnt, 16'd0);
`endif
        drive(1'b1, 4'd7, 1'b0, 4'd0, 1'b0);
        step();
        chk1("rst_rmw idx7 rsp", pred_rsp_valid, 1'b1);
        chk1("rst_rmw idx7 taken", pred_taken, 1'b0);
        idle_inputs();
        step();

`ifdef BHT_STATS_EN
        // idx 8: 01 -taken-> 10 (mispredict) -taken-> 11 -not-taken-> 10 (mispredict).
        single_update(4'd8, 1'b1);
        single_update(4'd8, 1'b1);
        chk16("stats pre upd", stat_upd_cnt, 16'd2);
        chk16("stats pre mispred", stat_mispred_cnt, 16'd1);
        single_update(4'd8, 1'b0);
        chk16("stats upd", stat_upd_cnt, 16'd3);
        chk16("stats mispred", stat_mispred_cnt, 16'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
